// File: rtl/mul_pkg.sv
// Shared definitions for the iterative multiply / multiply-accumulate unit.
package mul_pkg;

    localparam int MUL_WIDTH_DEF = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } mul_state_e;

endpackage

// File: rtl/mul_unit.sv
// Radix-2 shift-add multiplier with optional accumulate (MUL/MLA).
// Runs exactly WIDTH iterations per operation and reports the low WIDTH bits.
module mul_unit
    import mul_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             accumulate,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [WIDTH-1:0] op_acc,
    output logic             busy,
    output logic             done,
    output logic             stall,
    output logic [WIDTH-1:0] result,
    output logic             flag_n,
    output logic             flag_z
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    mul_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] acc_d;
    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic [WIDTH-1:0] result_q;
    logic             busy_q;
    logic             done_q;
    logic             flag_n_q;
    logic             flag_z_q;
    logic             accept;
    logic             last_step;

    // One shift-add step: the multiplicand is pre-shifted, so only bit 0 of
    // the multiplier decides whether it joins the running sum.
    always_comb begin
        acc_d     = acc_q + (mplier_q[0] ? mcand_q : '0);
        cnt_d     = cnt_q + CNT_ONE;
        accept    = start && (state_q != ST_RUN);
        last_step = (state_q == ST_RUN) && (cnt_q == CNT_LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            flag_n_q <= 1'b0;
            flag_z_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (accept) begin
                        state_q  <= ST_RUN;
                        busy_q   <= 1'b1;
                        cnt_q    <= '0;
                        acc_q    <= accumulate ? op_acc : '0;
                        mcand_q  <= op_a;
                        mplier_q <= op_b;
                    end else begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    acc_q    <= acc_d;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_d;
                    if (last_step) begin
                        state_q  <= ST_DONE;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        result_q <= acc_d;
                        flag_n_q <= acc_d[WIDTH-1];
                        flag_z_q <= (acc_d == '0);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Stall must rise in the same cycle a start is presented so the PC and
    // register-file write are frozen before the first iteration edge.
    assign stall  = rst_n && (busy_q || accept);
    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign flag_n = flag_n_q;
    assign flag_z = flag_z_q;

endmodule

// File: tb/tb_mul_unit.sv
// Directed-vector bench for mul_unit; a monitor checks every done pulse
// against a queue of expected results and arrival cycles.
module tb_mul_unit;

    localparam int W   = 32;
    localparam int LAT = 33;

    typedef struct {
        logic [W-1:0] res;
        logic         n;
        logic         z;
        int           cyc;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         accumulate;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic [W-1:0] op_acc;
    logic         busy;
    logic         done;
    logic         stall;
    logic [W-1:0] result;
    logic         flag_n;
    logic         flag_z;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_mis = 0;
    int   cyc   = 0;

    mul_unit #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .accumulate (accumulate),
        .op_a       (op_a),
        .op_b       (op_b),
        .op_acc     (op_acc),
        .busy       (busy),
        .done       (done),
        .stall      (stall),
        .result     (result),
        .flag_n     (flag_n),
        .flag_z     (flag_z)
    );

    // clock / cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        n_cmp++;
        if (act !== req) begin
            n_mis++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // monitor / scoreboard
    always @(posedge clk) begin
        #1;
        if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_mis++;
                $display("FAIL done_unexpected: got done=1 with result 0x%08h expected no done (cycle %0d)",
                         result, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("result", result, e.res);
                check("flag_n", W'(flag_n), W'(e.n));
                check("flag_z", W'(flag_z), W'(e.z));
                check("done_cycle", W'(cyc), W'(e.cyc));
            end
        end
    end

    // driver tasks
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c,
                         input logic mla, input logic [W-1:0] r, input logic n, input logic z);
        @(posedge clk); #1;
        op_a       = a;
        op_b       = b;
        op_acc     = c;
        accumulate = mla;
        start      = 1'b1;
        exp_q.push_back('{res: r, n: n, z: z, cyc: cyc + LAT});
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int left;
        left = budget;
        while (exp_q.size() != 0 && left > 0) begin
            @(posedge clk); #2;
            left--;
        end
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_mis++;
            $display("FAIL done_timeout: got %0d results outstanding expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        int c0;
        int quiet_done;

        rst_n      = 1'b0;
        start      = 1'b0;
        accumulate = 1'b0;
        op_a       = '0;
        op_b       = '0;
        op_acc     = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", W'(busy), '0);
        check("rst_done", W'(done), '0);
        check("rst_stall", W'(stall), '0);
        check("rst_result", result, '0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // basic MUL, MLA and MUL with the same operands
        issue(32'd3, 32'd5, 32'd0, 1'b0, 32'd15, 1'b0, 1'b0);
        wait_drain(60);
        issue(32'd7, 32'd6, 32'd100, 1'b1, 32'd142, 1'b0, 1'b0);
        wait_drain(60);
        issue(32'd7, 32'd6, 32'd100, 1'b0, 32'd42, 1'b0, 1'b0);
        wait_drain(60);

        // wrap-around and flags
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b0, 32'h0000_0001, 1'b0, 1'b0);
        wait_drain(60);
        issue(32'h0001_0000, 32'h0001_0000, 32'd0, 1'b0, 32'h0000_0000, 1'b0, 1'b1);
        wait_drain(60);
        issue(32'h8000_0000, 32'd1, 32'd0, 1'b0, 32'h8000_0000, 1'b1, 1'b0);
        wait_drain(60);
        issue(32'hFFFF_FFFF, 32'd2, 32'd3, 1'b1, 32'h0000_0001, 1'b0, 1'b0);
        wait_drain(60);

        // start pulsed mid-RUN with other operands must be ignored
        issue(32'd3, 32'd5, 32'd0, 1'b0, 32'd15, 1'b0, 1'b0);
        repeat (8) @(posedge clk);
        #1;
        op_a       = 32'd9;
        op_b       = 32'd9;
        op_acc     = 32'd1;
        accumulate = 1'b1;
        start      = 1'b1;
        check("run_busy", W'(busy), W'(1));
        @(posedge clk); #1;
        start = 1'b0;
        wait_drain(60);
        repeat (40) @(posedge clk);
        #1;
        check("no_extra_op", W'(exp_q.size()), '0);

        // reset in the middle of RUN
        @(posedge clk); #1;
        op_a       = 32'd3;
        op_b       = 32'd5;
        accumulate = 1'b0;
        start      = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_busy", W'(busy), '0);
        check("midrst_stall", W'(stall), '0);
        check("midrst_result", result, '0);
        check("midrst_flag_n", W'(flag_n), '0);
        @(posedge clk); #1;
        rst_n      = 1'b1;
        quiet_done = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done === 1'b1) quiet_done++;
        end
        check("midrst_no_done", W'(quiet_done), '0);

        // start accepted on the first edge after reset release
        rst_n = 1'b0;
        @(posedge clk); #1;
        op_a       = 32'd12;
        op_b       = 32'd12;
        op_acc     = 32'd6;
        accumulate = 1'b1;
        start      = 1'b1;
        rst_n      = 1'b1;
        exp_q.push_back('{res: 32'd150, n: 1'b0, z: 1'b0, cyc: cyc + LAT});
        @(posedge clk); #1;
        start = 1'b0;
        check("post_rst_busy", W'(busy), W'(1));
        wait_drain(60);

        // start held through DONE: back-to-back with no idle bubble
        @(posedge clk); #1;
        op_a       = 32'd2;
        op_b       = 32'd3;
        op_acc     = 32'd0;
        accumulate = 1'b0;
        start      = 1'b1;
        c0         = cyc;
        exp_q.push_back('{res: 32'd6, n: 1'b0, z: 1'b0, cyc: c0 + LAT});
        exp_q.push_back('{res: 32'd148, n: 1'b0, z: 1'b0, cyc: c0 + 2 * LAT});
        @(posedge clk); #1;
        op_a       = 32'd11;
        op_b       = 32'd13;
        op_acc     = 32'd5;
        accumulate = 1'b1;
        repeat (32) @(posedge clk);
        #1;
        check("b2b_done1", W'(done), W'(1));
        check("b2b_stall_done", W'(stall), W'(1));
        @(posedge clk); #1;
        start = 1'b0;
        check("b2b_busy", W'(busy), W'(1));
        wait_drain(80);

        repeat (3) @(posedge clk);
        #2;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
